// File: rtl/arb_pkg.sv
// Shared constants and FSM state type for the round-robin pop arbiter.
// No logic; types and default parameters only.
// Destination field is the top DEST_W bits of each word.
package arb_pkg;

  localparam int DEF_DW    = 6;
  localparam int DEF_N_IN  = 4;
  localparam int DEF_N_OUT = 4;
  localparam int DEF_CW    = 5;

  localparam int DEST_W    = 2;
  localparam int DEST_MSB  = DEF_DW - 1;
  localparam int DEST_LSB  = DEF_DW - DEST_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    STALL  = 2'd2
  } state_t;

endpackage

// File: rtl/rr_grant.sv
// Rotating-priority encoder: first requester at or after ptr wins.
// Latency: purely combinational.
// Backpressure: none; caller decides whether the grant is used.
module rr_grant #(
  parameter int N = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx,
  output logic          any
);

  logic [PW-1:0] idx;

  // Walk the requesters starting at ptr, wrapping, and keep the first hit.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = '0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(ptr) + i) % N);
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/rr_pop_arbiter.sv
// Round-robin pops one non-empty source FIFO per cycle and routes the word by its top 2 bits.
// Latency: pop to push is 2 cycles; 1 word/cycle; up to 2 words in flight. Optional ARB_COUNTERS_EN.
// Backpressure: any almost_full stops new pops at once; in-flight words always land; full dest sets error.
module rr_pop_arbiter
  import arb_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int N_IN  = DEF_N_IN,
  parameter int N_OUT = DEF_N_OUT
`ifdef ARB_COUNTERS_EN
  , parameter int CW  = DEF_CW
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [N_IN-1:0]    empty_i,
  input  logic [N_IN*DW-1:0] data_i,
  output logic [N_IN-1:0]    pop_o,
  input  logic [N_OUT-1:0]   almost_full_i,
  input  logic [N_OUT-1:0]   full_i,
  output logic [N_OUT-1:0]   push_o,
  output logic [DW-1:0]      data_o,
  output logic               error_o,
  output logic               idle_o
`ifdef ARB_COUNTERS_EN
  ,
  input  logic [1:0]         cnt_sel,
  output logic [CW-1:0]      cnt_o
`endif
);

  localparam int PW = (N_IN > 1) ? $clog2(N_IN) : 1;

  state_t              state, state_nxt;
  logic   [PW-1:0]     ptr;
  logic   [N_IN-1:0]   gnt;
  logic   [PW-1:0]     gnt_idx;
  logic                gnt_any;
  logic                any_af;
  logic                pop_ok;

  logic                s1_vld;
  logic   [PW-1:0]     s1_src;
  logic                s2_bad;

  logic   [DW-1:0]     src_word [N_IN];
  logic   [DW-1:0]     cap_word;
  logic   [DEST_W-1:0] cap_dest;
  logic   [DEST_W-1:0] cap_route;
  logic                cap_bad;
  logic   [N_OUT-1:0]  push_nxt;

  assign any_af = |almost_full_i;

  rr_grant #(.N(N_IN)) u_grant (
    .req     (~empty_i),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (gnt_any)
  );

  // Pop is combinational but held off during reset so no source loses a word.
  assign pop_ok = !reset && (state == ACTIVE) && enable && !any_af && gnt_any;
  assign pop_o  = pop_ok ? gnt : '0;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: almost_full dominates, then enable and source availability.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable && !(&empty_i) && !any_af) state_nxt = ACTIVE;
      ACTIVE:  if (any_af)                          state_nxt = STALL;
               else if (!enable || (&empty_i))     state_nxt = IDLE;
      STALL:   if (!any_af)                         state_nxt = enable ? ACTIVE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pointer moves just past the source actually popped.
  always_ff @(posedge clk) begin
    if (reset)       ptr <= '0;
    else if (pop_ok) ptr <= (gnt_idx == PW'(N_IN - 1)) ? '0 : gnt_idx + 1'b1;
  end

  for (genvar s = 0; s < N_IN; s++) begin : g_src
    assign src_word[s] = data_i[s*DW +: DW];
  end

  // Source data_out is valid the cycle after the pop; decode its destination then.
  always_comb begin
    cap_word  = src_word[s1_src];
    cap_dest  = cap_word[DW-1 -: DEST_W];
    cap_bad   = int'(cap_dest) >= N_OUT;
    cap_route = cap_bad ? '0 : cap_dest;
    push_nxt  = '0;
    push_nxt[cap_route] = 1'b1;
  end

  // Two-stage pipeline: remember the popped source, then present the word.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld <= 1'b0;
      s1_src <= '0;
      push_o <= '0;
      data_o <= '0;
      s2_bad <= 1'b0;
    end else begin
      s1_vld <= pop_ok;
      if (pop_ok) s1_src <= gnt_idx;
      push_o <= s1_vld ? push_nxt : '0;
      if (s1_vld) begin
        data_o <= cap_word;
        s2_bad <= cap_bad;
      end
    end
  end

  // Sticky error: a push landed on a full destination or carried an unused dest field.
  always_ff @(posedge clk) begin
    if (reset) error_o <= 1'b0;
    else if ((|(push_o & full_i)) || ((|push_o) && s2_bad)) error_o <= 1'b1;
  end

  assign idle_o = (state == IDLE) && !s1_vld && !(|push_o);

`ifdef ARB_COUNTERS_EN
  logic [CW-1:0]     cnt [N_OUT];
  logic [DEST_W-1:0] s2_route;

  // Saturating per-destination count of pushes that were actually accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_route <= '0;
      for (int i = 0; i < N_OUT; i++) cnt[i] <= '0;
    end else begin
      if (s1_vld) s2_route <= cap_route;
      if ((|push_o) && !full_i[s2_route] && (cnt[s2_route] != '1))
        cnt[s2_route] <= cnt[s2_route] + 1'b1;
    end
  end

  assign cnt_o = cnt[cnt_sel];
`endif

endmodule

// File: tb/tb_rr_pop_arbiter.sv
// Bench: source FIFO environment, queue-based reference model, directed and random stimulus.
// The model predicts every output each cycle; directed sections also pin literal values.
// Optional counter checks follow ARB_COUNTERS_EN.
`timescale 1ns/1ps
module tb_rr_pop_arbiter;

  localparam int NI = 4;
  localparam int NO = 4;
  localparam int M_IDLE = 0, M_ACT = 1, M_STALL = 2;

  logic        clk = 1'b0;
  logic        reset, enable;
  logic [3:0]  empty_i;
  logic [23:0] data_i;
  logic [3:0]  pop_o, almost_full_i, full_i, push_o;
  logic [5:0]  data_o;
  logic        error_o, idle_o;
`ifdef ARB_COUNTERS_EN
  logic [1:0]  cnt_sel;
  logic [4:0]  cnt_o;
`endif

  always #5 clk = ~clk;

  rr_pop_arbiter dut (
    .clk(clk), .reset(reset), .enable(enable),
    .empty_i(empty_i), .data_i(data_i), .pop_o(pop_o),
    .almost_full_i(almost_full_i), .full_i(full_i),
    .push_o(push_o), .data_o(data_o), .error_o(error_o), .idle_o(idle_o)
`ifdef ARB_COUNTERS_EN
    , .cnt_sel(cnt_sel), .cnt_o(cnt_o)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // stimulus knobs applied at each negedge
  logic       r_reset = 1'b1, r_en = 1'b0;
  logic [3:0] r_af = '0, r_full = '0;
  logic [1:0] r_sel = '0;

  // environment: source FIFOs as the DUT sees them
  logic [5:0] eq [NI][$];
  logic [5:0] edat [NI];

  // reference model
  typedef struct { logic [5:0] w; int due; } fl_t;
  logic [5:0] mq [NI][$];
  fl_t        fl [$];
  int         mstate = M_IDLE, mptr = 0;
  logic       merr = 1'b0;
  logic [5:0] mdata = '0;
  int         mcnt [NO];
  bit         mvalid = 1'b0;

  // last observed outputs, for literal checks
  logic [3:0] obs_pop, obs_push;
  logic [5:0] obs_data;
  logic       obs_err, obs_idle;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic refresh_env();
    for (int s = 0; s < NI; s++) begin
      empty_i[s] = (eq[s].size() == 0);
      data_i[s*6 +: 6] = edat[s];
    end
  endtask

  task automatic push_src(input int s, input logic [5:0] w);
    eq[s].push_back(w);
    mq[s].push_back(w);
    refresh_env();
  endtask

  task automatic step();
    logic [3:0] e_pop, e_push;
    logic [5:0] e_data, pw;
    logic       e_idle;
    int         e_src, pidx;
    bit         nonempty, af;
    fl_t        t;
    @(negedge clk);
    reset = r_reset; enable = r_en; almost_full_i = r_af; full_i = r_full;
`ifdef ARB_COUNTERS_EN
    cnt_sel = r_sel;
`endif
    #1;
    af = (r_af != 0);
    nonempty = 1'b0;
    for (int s = 0; s < NI; s++) if (mq[s].size() > 0) nonempty = 1'b1;
    e_pop = '0; e_src = -1;
    if (!r_reset && mstate == M_ACT && r_en && !af)
      for (int i = 0; i < NI; i++)
        if (e_src < 0 && mq[(mptr + i) % NI].size() > 0) e_src = (mptr + i) % NI;
    if (e_src >= 0) e_pop[e_src] = 1'b1;
    e_push = '0; e_data = mdata; pidx = -1; pw = '0;
    foreach (fl[k]) if (fl[k].due == cyc) pidx = k;
    if (pidx >= 0) begin
      pw = fl[pidx].w;
      e_push[pw[5:4]] = 1'b1;
      e_data = pw;
    end
    e_idle = (mstate == M_IDLE) && (fl.size() == 0);
    obs_pop = pop_o; obs_push = push_o; obs_data = data_o;
    obs_err = error_o; obs_idle = idle_o;
    if (mvalid) begin
      check("pop_o", pop_o, e_pop);
      check("push_o", push_o, e_push);
      check("data_o", data_o, e_data);
      check("error_o", error_o, merr);
      check("idle_o", idle_o, e_idle);
`ifdef ARB_COUNTERS_EN
      check("cnt_o", cnt_o, mcnt[r_sel]);
`endif
    end
    @(posedge clk);
    #1;
    for (int s = 0; s < NI; s++)
      if (obs_pop[s] && eq[s].size() > 0) edat[s] = eq[s].pop_front();
    if (r_reset) begin
      mstate = M_IDLE; mptr = 0; fl.delete(); merr = 1'b0; mdata = '0;
      for (int d = 0; d < NO; d++) mcnt[d] = 0;
      mvalid = 1'b1;
    end else begin
      if (pidx >= 0) begin
        mdata = pw;
        if (r_full[pw[5:4]]) merr = 1'b1;
        else if (mcnt[pw[5:4]] < 31) mcnt[pw[5:4]]++;
      end
      while (fl.size() > 0 && fl[0].due <= cyc) void'(fl.pop_front());
      if (e_src >= 0) begin
        t.w = mq[e_src].pop_front();
        t.due = cyc + 2;
        fl.push_back(t);
        mptr = (e_src + 1) % NI;
      end
      case (mstate)
        M_IDLE:  if (r_en && nonempty && !af) mstate = M_ACT;
        M_ACT:   if (af) mstate = M_STALL;
                 else if (!r_en || !nonempty) mstate = M_IDLE;
        default: if (!af) mstate = r_en ? M_ACT : M_IDLE;
      endcase
    end
    cyc++;
    refresh_env();
  endtask

  task automatic do_reset();
    r_reset = 1'b1; step(); r_reset = 1'b0;
  endtask

  initial begin
    int npush;
    for (int s = 0; s < NI; s++) edat[s] = '0;
    for (int d = 0; d < NO; d++) mcnt[d] = 0;
    reset = 1'b1; enable = 1'b0; almost_full_i = '0; full_i = '0;
`ifdef ARB_COUNTERS_EN
    cnt_sel = '0;
`endif
    refresh_env();

    // 1: two words in src0, both for dest 0
    do_reset();
    check("s1_reset_idle", obs_idle, 1'b1);
    r_en = 1'b1;
    push_src(0, 6'h03); push_src(0, 6'h06);
    step();
    step(); check("s1_pop_t",   obs_pop, 4'b0001);
    step(); check("s1_pop_t1",  obs_pop, 4'b0001);
    step(); check("s1_push_t2", obs_push, 4'b0001); check("s1_data_t2", obs_data, 6'h03);
            check("s1_nopop_t2", obs_pop, 4'b0000);
    step(); check("s1_push_t3", obs_push, 4'b0001); check("s1_data_t3", obs_data, 6'h06);

    // 2: one word in every source, rotation then wrap
    do_reset();
    push_src(0, 6'h05); push_src(1, 6'h1A); push_src(2, 6'h2B); push_src(3, 6'h3C);
    step();
    step(); check("s2_pop0", obs_pop, 4'b0001);
    step(); check("s2_pop1", obs_pop, 4'b0010);
    step(); check("s2_pop2", obs_pop, 4'b0100);
    step(); check("s2_pop3", obs_pop, 4'b1000);
    push_src(1, 6'h11); push_src(0, 6'h01);
    step(); check("s2_wrap", obs_pop, 4'b0001);
    for (int i = 0; i < 5; i++) step();

    // 3: almost_full mid-stream
    do_reset();
    for (int k = 0; k < 6; k++) push_src(0, 6'h20 | 6'(k));
    step(); step(); step();
    r_af = 4'b0100; npush = 0;
    step(); check("s3_af_nopop", obs_pop, 4'b0000);
    if (obs_push != 0) npush++;
    for (int i = 0; i < 2; i++) begin step(); if (obs_push != 0) npush++; end
    check("s3_inflight_pushes", npush, 2);
    r_af = 4'b0000;
    step(); check("s3_release_nopop", obs_pop, 4'b0000);
    step(); check("s3_resume", obs_pop, 4'b0001);
    for (int i = 0; i < 8; i++) step();

    // 4: push into a full destination
    do_reset();
    push_src(0, 6'h15);
    r_sel = 2'd1;
    step(); step(); step();
    r_full = 4'b0010;
    step(); check("s4_push", obs_push, 4'b0010); check("s4_data", obs_data, 6'h15);
    r_full = 4'b0000;
    step(); check("s4_err", obs_err, 1'b1);
    step(); check("s4_err_sticky", obs_err, 1'b1);
`ifdef ARB_COUNTERS_EN
    check("s4_cnt1", cnt_o, 0);
`endif

    // 5: reset with two words in flight
    do_reset();
    push_src(2, 6'h31); push_src(2, 6'h32); push_src(2, 6'h33);
    step();
    step(); check("s5_pop_a", obs_pop, 4'b0100);
    step(); check("s5_pop_b", obs_pop, 4'b0100);
    r_reset = 1'b1;
    step(); check("s5_pop_gated", obs_pop, 4'b0000);
    r_reset = 1'b0;
    push_src(0, 6'h0A);
    step(); check("s5_idle", obs_idle, 1'b1); check("s5_nopush0", obs_push, 4'b0000);
    step(); check("s5_nopush1", obs_push, 4'b0000); check("s5_grant0", obs_pop, 4'b0001);
    for (int i = 0; i < 6; i++) step();

    // 6: 33 words to dest 3, enable dropped mid-stream
    do_reset();
    r_sel = 2'd3;
    for (int k = 0; k < 33; k++) push_src(k % NI, 6'h30 | 6'(k % 16));
    for (int i = 0; i < 20; i++) step();
    r_en = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("s6_idle", obs_idle, 1'b1);
    r_en = 1'b1;
    for (int i = 0; i < 24; i++) step();
`ifdef ARB_COUNTERS_EN
    check("s6_cnt_sat", cnt_o, 31);
`endif

    // random traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      for (int s = 0; s < NI; s++)
        if ($urandom_range(0, 9) < 3 && eq[s].size() < 6) push_src(s, 6'($urandom));
      r_en    = ($urandom_range(0, 9) != 0);
      r_af    = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
      r_full  = ($urandom_range(0, 11) == 0) ? (4'b0001 << $urandom_range(0, 3)) : 4'b0000;
      r_reset = ($urandom_range(0, 149) == 0);
      r_sel   = 2'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
